// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer arithmetic blocks: default widths and
// the partial-product helper used by the pipelined multiplier.
package int_alu_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int TAG_WIDTH_DEF  = 4;
   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_PROD_WIDTH = 2 * MAX_DATA_WIDTH;

   function automatic bit width_is_legal(input int width);
      return (width == 4) || (width == 8) || (width == 16) ||
             (width == 32) || (width == 64);
   endfunction

   // One multiplier row: the multiplicand extended to the product width and
   // shifted to bit position idx. In signed mode the multiplier MSB carries
   // weight -2^(width-1), so that row is negated; everything wraps mod 2^(2*width).
   function automatic logic [MAX_PROD_WIDTH-1:0] pp_row(
      input logic [MAX_DATA_WIDTH-1:0] cand,
      input logic                      plier_bit,
      input int                        idx,
      input int                        width,
      input logic                      is_signed
   );
      logic [MAX_PROD_WIDTH-1:0] ext;
      logic [5:0]                msb;
      logic                      sign_bit;
      msb      = 6'(width - 1);
      sign_bit = is_signed & cand[msb];
      ext      = {{MAX_DATA_WIDTH{1'b0}}, cand};
      for (int k = 0; k < MAX_PROD_WIDTH; k++) begin
         if (k >= width) ext[k] = sign_bit;
      end
      if (!plier_bit) begin
         ext = '0;
      end else begin
         ext = ext << idx;
         if (is_signed && (idx == width - 1)) ext = -ext;
      end
      return ext;
   endfunction

endpackage

// File: rtl/int_mult_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier; the master
// side issues operand pairs and consumes results.
interface int_mult_pipe_if #(
   parameter int DATA_WIDTH = int_alu_pkg::DATA_WIDTH_DEF,
   parameter int TAG_WIDTH  = int_alu_pkg::TAG_WIDTH_DEF
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_signed;
   logic [DATA_WIDTH-1:0]   m_cand;
   logic [DATA_WIDTH-1:0]   m_plier;
   logic [TAG_WIDTH-1:0]    in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*DATA_WIDTH-1:0] result;
   logic [TAG_WIDTH-1:0]    out_tag;

   modport master (
      output in_valid, in_signed, m_cand, m_plier, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag
   );

   modport slave (
      input  in_valid, in_signed, m_cand, m_plier, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag
   );

endinterface

// File: rtl/int_mult_tree_stage.sv
// One registered level of the product adder tree: sums operand pairs, carries
// valid and tag, and holds while the level below it is full and stalled.
module int_mult_tree_stage
   import int_alu_pkg::*;
#(
   parameter int N_IN      = 2,
   parameter int PW        = 2 * DATA_WIDTH_DEF,
   parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_valid,
   input  logic [N_IN-1:0][PW-1:0]     i_ops,
   input  logic [TAG_WIDTH-1:0]        i_tag,
   input  logic                        i_down_ready,
   output logic                        o_ready,
   output logic                        o_valid,
   output logic [N_IN/2-1:0][PW-1:0]   o_ops,
   output logic [TAG_WIDTH-1:0]        o_tag
);
   localparam int N_OUT = N_IN / 2;

   logic                       r_valid;
   logic [N_OUT-1:0][PW-1:0]   r_ops;
   logic [TAG_WIDTH-1:0]       r_tag;
   logic [N_OUT-1:0][PW-1:0]   w_sums;

   // An empty level always takes new data, so bubbles collapse upstream.
   assign o_ready = !r_valid || i_down_ready;

   always_comb begin
      w_sums = '0;
      for (int j = 0; j < N_OUT; j++) begin
         w_sums[j] = i_ops[2*j] + i_ops[2*j+1];
      end
   end

   // NOTE: state uses non-blocking assignments so each level samples its
   // upstream neighbour's pre-edge value and the levels move in lockstep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (o_ready) begin
         r_valid <= i_valid;
      end
   end

   // NOTE: operand and tag registers are not reset; the valid bit alone
   // qualifies them and the top masks the outputs whenever valid is low.
   always_ff @(posedge clk) begin
      if (o_ready && i_valid) begin
         r_ops <= w_sums;
         r_tag <= i_tag;
      end
   end

   assign o_valid = r_valid;
   assign o_ops   = r_ops;
   assign o_tag   = r_tag;

endmodule

// File: rtl/int_mult_pipe.sv
// Pipelined signed/unsigned integer multiplier: partial products formed in the
// accept cycle, reduced by a log2(DATA_WIDTH)-level registered adder tree.
module int_mult_pipe
   import int_alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   int_mult_pipe_if.slave bus
);
   localparam int LAT = $clog2(DATA_WIDTH);
   localparam int PW  = 2 * DATA_WIDTH;

   if (!width_is_legal(DATA_WIDTH)) begin : g_width_check
      $error("int_mult_pipe: DATA_WIDTH=%0d must be a power of two in 4..64", DATA_WIDTH);
   end

   logic [DATA_WIDTH-1:0][PW-1:0] w_pp;
   logic [LAT:0]                  w_vld;
   logic [LAT:0]                  w_rdy;
   logic [LAT:0][TAG_WIDTH-1:0]   w_tag;

   // NOTE: every always_comb output gets a default first, so no path through
   // the block can leave it unassigned and infer a latch.
   always_comb begin
      w_pp = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_pp[i] = PW'(pp_row(MAX_DATA_WIDTH'(bus.m_cand), bus.m_plier[i], i,
                              DATA_WIDTH, bus.in_signed));
      end
   end

   assign w_vld[0]   = bus.in_valid;
   assign w_tag[0]   = bus.in_tag;
   assign w_rdy[LAT] = bus.out_ready;

   // Level k reduces DATA_WIDTH>>k operands to half as many; the last level
   // leaves the single full-width product.
   for (genvar k = 0; k < LAT; k++) begin : g_lvl
      localparam int N_IN = DATA_WIDTH >> k;

      logic [N_IN-1:0][PW-1:0]   w_ops_in;
      logic [N_IN/2-1:0][PW-1:0] w_ops;

      if (k == 0) begin : g_src_pp
         assign w_ops_in = w_pp;
      end else begin : g_src_lvl
         assign w_ops_in = g_lvl[k-1].w_ops;
      end

      int_mult_tree_stage #(
         .N_IN      (N_IN),
         .PW        (PW),
         .TAG_WIDTH (TAG_WIDTH)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_valid      (w_vld[k]),
         .i_ops        (w_ops_in),
         .i_tag        (w_tag[k]),
         .i_down_ready (w_rdy[k+1]),
         .o_ready      (w_rdy[k]),
         .o_valid      (w_vld[k+1]),
         .o_ops        (w_ops),
         .o_tag        (w_tag[k+1])
      );
   end

   // Masking keeps result/out_tag at zero while empty or in reset, since the
   // data registers themselves carry no reset.
   assign bus.in_ready  = w_rdy[0];
   assign bus.out_valid = w_vld[LAT];
   assign bus.result    = w_vld[LAT] ? g_lvl[LAT-1].w_ops[0] : '0;
   assign bus.out_tag   = w_vld[LAT] ? w_tag[LAT] : '0;

endmodule

// File: tb/tb_int_mult_pipe.sv
// Self-checking bench for int_mult_pipe (DATA_WIDTH=32): directed scenarios
// plus a scoreboard that checks every output transfer against a product model.
module tb_int_mult_pipe;
   localparam int W   = 32;
   localparam int TW  = 4;
   localparam int LAT = 5;
   localparam int PW  = 2 * W;

   typedef struct {
      logic [PW-1:0] res;
      logic [TW-1:0] tag;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t mon_e;

   int_mult_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) bus ();

   int_mult_pipe #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
      logic [PW-1:0] ea, eb;
      ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         4:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   // Scoreboard: every output transfer is popped and compared in order.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: result=%h tag=%0d appeared, required no output",
                     bus.result, bus.out_tag);
         end else begin
            mon_e = sb.pop_front();
            if (bus.result !== mon_e.res || bus.out_tag !== mon_e.tag) begin
               n_fail++;
               $display("FAIL sb_result: got result=%h tag=%0d, required result=%h tag=%0d",
                        bus.result, bus.out_tag, mon_e.res, mon_e.tag);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.m_cand    = W'($urandom);
      bus.m_plier   = W'($urandom);
      bus.in_signed = 1'($urandom);
      bus.in_tag    = TW'($urandom);
   endtask

   // Presents one op and returns #1 after the edge that accepted it.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [TW-1:0] tag, input logic [PW-1:0] exp_res,
                        output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      bus.in_valid  = 1'b1;
      bus.m_cand    = a;
      bus.m_plier   = b;
      bus.in_signed = s;
      bus.in_tag    = tag;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back('{exp_res, tag});
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (!done) begin
            waited++;
            if (waited >= 200) begin
               n_checks++;
               n_fail++;
               $display("FAIL issue_timeout: in_ready=0 for %0d cycles, required 1", waited);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_idle: out_valid=%b after drain, required 0", bus.out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.out_ready = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
      end
      n_checks++;
      if (bus.result !== '0) begin
         n_fail++; $display("FAIL reset_result: got %h, required 0", bus.result);
      end
      n_checks++;
      if (bus.out_tag !== '0) begin
         n_fail++; $display("FAIL reset_out_tag: got %0d, required 0", bus.out_tag);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned_max();
      int waited, cycles;
      bus.out_ready = 1'b1;
      issue('1, '1, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001, waited);
      idle();
      n_checks++;
      if (waited !== 0) begin
         n_fail++; $display("FAIL first_accept: waited %0d cycles, required 0", waited);
      end
      cycles = 1;
      while (!bus.out_valid && cycles < 4 * LAT) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_checks++;
      if (cycles !== LAT) begin
         n_fail++; $display("FAIL latency: out_valid after %0d cycles, required %0d", cycles, LAT);
      end
      n_checks++;
      if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++; $display("FAIL umax_result: got %h, required fffffffe00000001", bus.result);
      end
      n_checks++;
      if (bus.out_tag !== 4'd3) begin
         n_fail++; $display("FAIL umax_tag: got %0d, required 3", bus.out_tag);
      end
      wait_drain(50);
   endtask

   task automatic test_signed_boundaries();
      int waited;
      bus.out_ready = 1'b1;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd1, 64'h0000_0000_0000_0001, waited);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2, 64'h4000_0000_0000_0000, waited);
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 4'd4, 64'hFFFF_FFFF_8000_0000, waited);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd5, 64'hC000_0000_8000_0000, waited);
      issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 4'd6, 64'hFFFF_FFFF_8000_0001, waited);
      issue(32'h8000_0000, 32'h0000_0002, 1'b0, 4'd7, 64'h0000_0001_0000_0000, waited);
      idle();
      wait_drain(50);
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      fork
         begin
            int waited;
            logic [W-1:0] a, b;
            for (int i = 0; i < 10; i++) begin
               a = rnd_op();
               b = rnd_op();
               issue(a, b, 1'(i), TW'(i), model(a, b, 1'(i)), waited);
               n_checks++;
               if (waited !== 0) begin
                  n_fail++; $display("FAIL b2b_accept: op %0d waited %0d cycles, required 0", i, waited);
               end
            end
            idle();
         end
         begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 40) begin
               @(posedge clk); #1;
               n++;
            end
            for (int j = 0; j < 10; j++) begin
               n_checks++;
               if (bus.out_valid !== 1'b1 || bus.out_tag !== TW'(j)) begin
                  n_fail++;
                  $display("FAIL b2b_stream: slot %0d out_valid=%b tag=%0d, required 1 and %0d",
                           j, bus.out_valid, bus.out_tag, j);
               end
               @(posedge clk); #1;
            end
         end
      join
      wait_drain(50);
   endtask

   task automatic test_stall();
      int waited;
      logic [W-1:0] a0, b0, a, b;
      logic [PW-1:0] exp0;
      bus.out_ready = 1'b0;
      a0   = W'($urandom);
      b0   = W'($urandom);
      exp0 = model(a0, b0, 1'b1);
      issue(a0, b0, 1'b1, 4'd5, exp0, waited);
      for (int i = 1; i < LAT; i++) begin
         a = rnd_op();
         b = rnd_op();
         issue(a, b, 1'(i), TW'(5 + i), model(a, b, 1'(i)), waited);
         n_checks++;
         if (waited !== 0) begin
            n_fail++; $display("FAIL stall_fill: op %0d waited %0d cycles, required 0", i, waited);
         end
      end
      idle();
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== exp0 || bus.out_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d valid=%b result=%h tag=%0d, required 1 %h 5",
                     c, bus.out_valid, bus.result, bus.out_tag, exp0);
         end
         n_checks++;
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_in_ready: cycle %0d got %b, required 0", c, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      issue(a, b, 1'b0, 4'd10, model(a, b, 1'b0), waited);
      idle();
      n_checks++;
      if (waited !== 0) begin
         n_fail++; $display("FAIL stall_release: waited %0d cycles, required 0", waited);
      end
      wait_drain(50);
   endtask

   task automatic test_reset_in_flight();
      int waited, n, seen;
      logic [W-1:0] a, b;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = rnd_op();
         b = rnd_op();
         issue(a, b, 1'(i), TW'(i), model(a, b, 1'(i)), waited);
      end
      idle();
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rif_filled: out_valid=%b before reset, required 1", bus.out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.out_tag !== '0) begin
         n_fail++;
         $display("FAIL rif_async_clear: valid=%b result=%h tag=%0d, required 0 0 0",
                  bus.out_valid, bus.result, bus.out_tag);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rif_in_ready: got %b, required 1", bus.in_ready);
      end
      sb.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      repeat (3 * LAT) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL rif_stale: %0d stale output cycles, required 0", seen);
      end
      issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 4'd12, 64'hFFFF_FFFF_FFFF_FFFA, waited);
      idle();
      wait_drain(50);
   endtask

   task automatic test_random();
      bit done_flag;
      done_flag = 1'b0;
      fork
         begin
            int waited;
            logic [W-1:0] a, b;
            logic s;
            for (int n = 0; n < 10000; n++) begin
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  @(posedge clk); #1;
               end
               a = rnd_op();
               b = rnd_op();
               s = 1'($urandom);
               issue(a, b, s, TW'(n), model(a, b, s), waited);
            end
            idle();
            done_flag = 1'b1;
         end
         begin
            while (!done_flag) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
      join
      wait_drain(500);
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed_boundaries();
      test_back_to_back();
      test_stall();
      test_reset_in_flight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
